// File: rtl/prog_loader.sv
// Host-side program loader: turns a byte command stream into memory loads/reads,
// PC presets and run/step/stop control of an attached CPU, sharing one memory bus.
module prog_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  input  logic [7:0] cpu_mem_din,
  input  logic [7:0] cpu_mem_addr,
  input  logic       cpu_mem_we,
  output logic [7:0] cpu_mem_dout,
  output logic [7:0] mem_din,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  input  logic [7:0] mem_dout,
  output logic [7:0] pc_set_val,
  output logic       pc_set_wr,
  output logic       run,
  input  logic       cpu_halt,
  input  logic       cpu_done,
  output logic [7:0] retired,
  output logic       err
);

  typedef enum logic [3:0] {
    CMD, LD_ADDR, LD_LEN, LD_DATA, RD_ADDR, RD_RSP,
    RUN_PC, SET_PC, RUNNING, STEP_GO, STOPPING
  } state_t;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_RUN   = 8'h02;
  localparam logic [7:0] OP_STOP  = 8'h03;
  localparam logic [7:0] OP_READ  = 8'h04;
  localparam logic [7:0] OP_STEP  = 8'h05;
  localparam logic [7:0] OP_RETIR = 8'h06;

  state_t     state, nxt;
  logic [7:0] addr_ptr;
  logic [7:0] count;
  logic       bus_cpu;    // CPU owns the memory bus
  logic       ld_active;  // loader is streaming write data
  logic       rd_active;  // loader is taking a read address
  logic       acc;
  logic       cmd_bad;

  assign acc     = host_valid && host_ready;
  assign cmd_bad = (host_data == 8'h00) || (host_data > OP_RETIR);

  always_comb begin
    nxt = state;
    unique case (state)
      CMD: if (acc) begin
        case (host_data)
          OP_LOAD:  nxt = LD_ADDR;
          OP_RUN:   nxt = RUN_PC;
          OP_READ:  nxt = RD_ADDR;
          OP_STEP:  nxt = STEP_GO;
          OP_RETIR: nxt = RD_RSP;
          default:  nxt = CMD;
        endcase
      end
      LD_ADDR:  if (acc) nxt = LD_LEN;
      LD_LEN:   if (acc) nxt = LD_DATA;
      // count of 0 means 256: it wraps to 0xFF on the first byte
      LD_DATA:  if (acc && count == 8'd1) nxt = CMD;
      RD_ADDR:  if (acc) nxt = RD_RSP;
      RD_RSP:   if (rsp_ready) nxt = CMD;
      RUN_PC:   if (acc) nxt = SET_PC;
      SET_PC:   nxt = RUNNING;
      RUNNING:  if (acc && host_data == OP_STOP) nxt = STOPPING;
      STEP_GO:  nxt = STOPPING;
      STOPPING: if (cpu_halt) nxt = CMD;
      default:  nxt = CMD;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CMD;
      host_ready <= 1'b1;
      run        <= 1'b0;
      pc_set_wr  <= 1'b0;
      rsp_valid  <= 1'b0;
      bus_cpu    <= 1'b0;
      ld_active  <= 1'b0;
      rd_active  <= 1'b0;
      rsp_data   <= 8'h00;
      pc_set_val <= 8'h00;
      err        <= 1'b0;
      retired    <= 8'h00;
      addr_ptr   <= 8'h00;
      count      <= 8'h00;
    end else begin
      state      <= nxt;
      host_ready <= nxt inside {CMD, LD_ADDR, LD_LEN, LD_DATA, RD_ADDR, RUN_PC, RUNNING};
      run        <= nxt inside {RUNNING, STEP_GO};
      pc_set_wr  <= (nxt == SET_PC);
      rsp_valid  <= (nxt == RD_RSP);
      bus_cpu    <= nxt inside {RUNNING, STEP_GO, STOPPING};
      ld_active  <= (nxt == LD_DATA);
      rd_active  <= (nxt == RD_ADDR);

      case (state)
        CMD: if (acc) begin
          if (host_data == OP_RETIR) rsp_data <= retired;
          if (cmd_bad) err <= 1'b1;
        end
        LD_ADDR: if (acc) addr_ptr <= host_data;
        LD_LEN:  if (acc) count <= host_data;
        LD_DATA: if (acc) begin
          addr_ptr <= addr_ptr + 8'd1;
          count    <= count - 8'd1;
        end
        RD_ADDR: if (acc) rsp_data <= mem_dout;
        RUN_PC:  if (acc) pc_set_val <= host_data;
        RUNNING: if (acc && host_data != OP_STOP) err <= 1'b1;
        default: ;
      endcase

      if (state == SET_PC)
        retired <= 8'h00;
      else if (bus_cpu && cpu_done)
        retired <= retired + 8'd1;
    end
  end

  assign cpu_mem_dout = mem_dout;
  assign mem_addr = bus_cpu ? cpu_mem_addr : (rd_active ? host_data : addr_ptr);
  assign mem_din  = bus_cpu ? cpu_mem_din  : host_data;
  assign mem_we   = bus_cpu ? cpu_mem_we   : (ld_active && host_valid && host_ready);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed sequences, a stateful vector table
// and randomized load/read/step traffic against a memory/counter reference model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] cpu_mem_din, cpu_mem_addr;
  logic       cpu_mem_we;
  logic [7:0] cpu_mem_dout;
  logic [7:0] mem_din, mem_addr;
  logic       mem_we;
  logic [7:0] mem_dout;
  logic [7:0] pc_set_val;
  logic       pc_set_wr;
  logic       run;
  logic       cpu_halt, cpu_done;
  logic [7:0] retired;
  logic       err;

  prog_loader dut (
    .clk(clk), .rst(rst),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .cpu_mem_din(cpu_mem_din), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_we(cpu_mem_we),
    .cpu_mem_dout(cpu_mem_dout),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
    .pc_set_val(pc_set_val), .pc_set_wr(pc_set_wr), .run(run),
    .cpu_halt(cpu_halt), .cpu_done(cpu_done), .retired(retired), .err(err)
  );

  always #5 clk = ~clk;

  // Memory: async read, write on clock edge.
  logic [7:0] mem [256];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_din;

  // Reference model state.
  logic [7:0] exp_mem [256];
  logic [7:0] exp_retired;
  logic       exp_err;

  // Observers sampled mid-cycle.
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int run_cnt, pc_cnt;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin wa.push_back(mem_addr); wd.push_back(mem_din); end
    if (run === 1'b1) run_cnt++;
    if (pc_set_wr === 1'b1) pc_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a byte until it is accepted; returns 1 after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    host_data = b; host_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (host_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'(n), 32'd0);
        host_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  task automatic load_rand(input logic [7:0] a, input int n);
    logic [7:0] d;
    send(8'h01); send(a); send(8'(n));
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      send(d);
      exp_mem[8'(a + i)] = d;
    end
  endtask

  task automatic read_chk(input logic [7:0] a);
    send(8'h04); send(a);
    chk("rd_valid", rsp_valid, 1'b1);
    chk("rd_data", rsp_data, exp_mem[a]);
    ack_rsp();
  endtask

  task automatic query_retired();
    send(8'h06);
    chk("retired_rsp", {rsp_valid, rsp_data}, {1'b1, exp_retired});
    ack_rsp();
  endtask

  task automatic step(input logic done);
    send(8'h05);
    chk("step_run", run, 1'b1);
    cpu_done = done; tick(); cpu_done = 1'b0;
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    if (done) exp_retired = exp_retired + 8'd1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ready, run, rv, pcwr, err;
    logic [7:0] rsp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int bad;
    logic [7:0] d;

    tbl[0]  = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[8]  = '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[11] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[12] = '{8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[13] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

    rst = 1'b1; host_data = 8'h00; host_valid = 1'b0; rsp_ready = 1'b0;
    cpu_mem_din = 8'h00; cpu_mem_addr = 8'h00; cpu_mem_we = 1'b0;
    cpu_halt = 1'b0; cpu_done = 1'b0;
    exp_retired = 8'h00; exp_err = 1'b0;
    tick(3);
    chk("rst_outs", {host_ready, run, pc_set_wr, mem_we, rsp_valid, err},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_retired", retired, 8'h00);
    rst = 1'b0;
    tick();

    // Wrap-around load of length 256 (0x00).
    wa.delete(); wd.delete();
    send(8'h01); send(8'hFE); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      d = 8'(i * 7 + 3);
      send(d);
      exp_mem[8'(8'hFE + i)] = d;
      if (i == 254) chk("wrap_still_loading", {host_ready, 8'(wa.size())}, {1'b1, 8'd255});
    end
    send(8'h03);
    tick(2);
    chk("wrap_count", wa.size(), 256);
    bad = 0;
    for (int i = 0; i < wa.size() && i < 256; i++)
      if (wa[i] !== 8'(8'hFE + i) || wd[i] !== 8'(i * 7 + 3)) bad++;
    chk("wrap_writes", bad, 0);
    chk("wrap_no_err", err, 1'b0);

    // Basic load.
    wa.delete(); wd.delete();
    send(8'h01); send(8'h10); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    exp_mem[8'h10] = 8'hAA; exp_mem[8'h11] = 8'hBB; exp_mem[8'h12] = 8'hCC;
    tick(3);
    chk("load_count", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("load_w0", {wa[0], wd[0]}, 16'h10AA);
      chk("load_w1", {wa[1], wd[1]}, 16'h11BB);
      chk("load_w2", {wa[2], wd[2]}, 16'h12CC);
    end
    chk("load_idle", host_ready, 1'b1);

    // Read with held-off response.
    send(8'h04); send(8'h11);
    chk("rd_first", {rsp_valid, rsp_data}, {1'b1, 8'hBB});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rd_hold", {rsp_valid, host_ready, rsp_data}, {1'b1, 1'b0, 8'hBB});
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("rd_release", {rsp_valid, host_ready}, {1'b0, 1'b1});

    // Run / stop.
    pc_cnt = 0;
    send(8'h02); send(8'h10);
    chk("set_pc", {pc_set_wr, pc_set_val, run}, {1'b1, 8'h10, 1'b0});
    tick();
    chk("running", {run, pc_set_wr, host_ready}, {1'b1, 1'b0, 1'b1});
    exp_retired = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cpu_done = 1'b1; tick(); cpu_done = 1'b0; tick();
      exp_retired = exp_retired + 8'd1;
    end
    cpu_mem_addr = 8'h33; cpu_mem_din = 8'h44; cpu_mem_we = 1'b1;
    @(negedge clk);
    chk("bus_cpu", {mem_we, mem_addr, mem_din}, {1'b1, 8'h33, 8'h44});
    @(posedge clk); #1;
    cpu_mem_we = 1'b0;
    exp_mem[8'h33] = 8'h44;
    chk("pc_pulses", pc_cnt, 1);
    send(8'h03);
    chk("stopping", {run, host_ready}, {1'b0, 1'b0});
    tick(3);
    chk("wait_halt", host_ready, 1'b0);
    cpu_halt = 1'b1; tick(); cpu_halt = 1'b0;
    chk("halted", host_ready, 1'b1);
    query_retired();

    // Single step.
    run_cnt = 0;
    step(1'b1);
    chk("step_run_cycles", run_cnt, 1);
    query_retired();

    // Stateful vector table (CPU reports halted throughout).
    cpu_halt = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].b);
      chk($sformatf("tbl%0d_ctl", i),
          {host_ready, run, rsp_valid, pc_set_wr, err},
          {tbl[i].ready, tbl[i].run, tbl[i].rv, tbl[i].pcwr, tbl[i].err});
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_rsp", i), rsp_data, tbl[i].rsp);
        ack_rsp();
      end
    end
    cpu_halt = 1'b0;
    tick();
    exp_mem[8'h20] = 8'h5A; exp_mem[8'h21] = 8'hA5;
    exp_retired = 8'h00; exp_err = 1'b1;

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: load_rand(8'($urandom), $urandom_range(1, 6));
        1: read_chk(8'($urandom));
        2: step(1'($urandom));
        default: query_retired();
      endcase
    end
    chk("rand_err_sticky", err, exp_err);
    query_retired();

    // Reset in the middle of a load.
    wa.delete(); wd.delete();
    send(8'h01); send(8'h50); send(8'h05); send(8'h11); send(8'h22);
    rst = 1'b1; tick();
    chk("midrst_outs", {host_ready, run, pc_set_wr, mem_we, rsp_valid, err},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("midrst_regs", {rsp_data, retired}, 16'h0000);
    rst = 1'b0;
    exp_err = 1'b0; exp_retired = 8'h00;
    exp_mem[8'h50] = 8'h11; exp_mem[8'h51] = 8'h22;
    send(8'h03);
    tick(2);
    chk("midrst_writes", wa.size(), 2);
    chk("midrst_err", err, exp_err);
    read_chk(8'h50);
    read_chk(8'h51);
    query_retired();

    // Reset while running drops run on the next cycle.
    send(8'h02); send(8'h00);
    tick();
    chk("run_before_rst", run, 1'b1);
    rst = 1'b1; tick();
    chk("run_after_rst", {run, host_ready}, {1'b0, 1'b1});
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
